// File: rtl/fact_engine.sv
// Iterative factorial engine: a single Moore FSM drives a shift-add multiplier, one multiplier bit per cycle.
// Optional dynamic overflow abort is compiled in when FACT_OVF_CHECK_EN is defined.
module fact_engine #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 32,
  parameter int MAX_N = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [IN_W-1:0]  n,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [OUT_W-1:0] result
);

  localparam int IDX_W = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int P_W   = OUT_W + IN_W;
  localparam logic [31:0] MAX_U = MAX_N;

  typedef enum logic [1:0] {IDLE, MULT, FIN} state_t;

  state_t           state;
  logic [OUT_W-1:0] acc;
  logic [IN_W-1:0]  cnt;
  logic [IDX_W-1:0] idx;
  logic [P_W-1:0]   prod;

  logic [P_W-1:0]   addend;
  logic [P_W-1:0]   prod_next;
  logic [IN_W-1:0]  cnt_dec;
  logic             step_end;
  logic             range_err;
  logic             n_small;

`ifdef FACT_OVF_CHECK_EN
  // Any bit above the result width means the running product no longer fits.
  function automatic logic ovf(input logic [P_W-1:0] p);
    return |p[P_W-1:OUT_W];
  endfunction
`endif

  always_comb begin
    addend    = cnt[idx] ? ({{IN_W{1'b0}}, acc} << idx) : '0;
    prod_next = prod + addend;
    cnt_dec   = cnt - IN_W'(1);
    step_end  = (idx == IDX_W'(IN_W - 1));
    range_err = (32'(n) > MAX_U);
    n_small   = (n <= IN_W'(1));
  end

  assign busy = (state == MULT);
  assign done = (state == FIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      idx    <= '0;
      prod   <= '0;
      error  <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            acc  <= OUT_W'(1);
            cnt  <= n;
            idx  <= '0;
            prod <= '0;
            if (range_err) begin
              error  <= 1'b1;
              result <= '0;
              state  <= FIN;
            end else if (n_small) begin
              error  <= 1'b0;
              result <= OUT_W'(1);
              state  <= FIN;
            end else begin
              error  <= 1'b0;
              result <= '0;
              state  <= MULT;
            end
          end
        end
        MULT: begin
          if (!step_end) begin
            prod <= prod_next;
            idx  <= idx + 1'b1;
          end else begin
            // End of one multiply step: fold the product back into acc.
            acc  <= prod_next[OUT_W-1:0];
            cnt  <= cnt_dec;
            prod <= '0;
            idx  <= '0;
`ifdef FACT_OVF_CHECK_EN
            if (ovf(prod_next)) begin
              error  <= 1'b1;
              result <= '0;
              state  <= FIN;
            end else
`endif
            if (cnt_dec == IN_W'(1)) begin
              result <= prod_next[OUT_W-1:0];
              state  <= FIN;
            end
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fact_engine.sv
// Scoreboard bench for fact_engine: default instance plus a MAX_N=15 instance for the overflow scenario.
`timescale 1ns/1ps
module tb_fact_engine;

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          cyc;
    int          bsy;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        go, go15;
  logic [3:0]  n, n15;
  logic        busy, done, error;
  logic [31:0] result;
  logic        busy15, done15, error15;
  logic [31:0] result15;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   bcnt = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fact_engine dut (
    .clk(clk), .rst_n(rst_n), .go(go), .n(n),
    .busy(busy), .done(done), .error(error), .result(result)
  );

  fact_engine #(.IN_W(4), .OUT_W(32), .MAX_N(15)) dut15 (
    .clk(clk), .rst_n(rst_n), .go(go15), .n(n15),
    .busy(busy15), .done(done15), .error(error15), .result(result15)
  );

  function automatic exp_t model(input int nv, input int k);
    exp_t e;
    logic [31:0] r;
    r = 32'd1;
    if (nv > 12) begin
      e.res = 32'd0;
      e.err = 1'b1;
      e.bsy = 0;
    end else begin
      for (int i = 2; i <= nv; i++) r = r * 32'(i);
      e.res = r;
      e.err = 1'b0;
      e.bsy = (nv <= 1) ? 0 : (nv - 1) * 4;
    end
    e.cyc = k + e.bsy + 1;
    return e;
  endfunction

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      bcnt = 0;
    end else begin
      if (busy) bcnt++;
      if (done) begin
        if (sbq.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_done at cycle %0d result=%0d", cyc, result);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          vectors++;
          if (result !== e.res) begin
            miscompares++;
            $display("FAIL sb_result got=%0d exp=%0d", result, e.res);
          end
          vectors++;
          if (error !== e.err) begin
            miscompares++;
            $display("FAIL sb_error got=%0b exp=%0b", error, e.err);
          end
          vectors++;
          if (cyc !== e.cyc) begin
            miscompares++;
            $display("FAIL sb_done_cycle got=%0d exp=%0d", cyc, e.cyc);
          end
          vectors++;
          if (bcnt !== e.bsy) begin
            miscompares++;
            $display("FAIL sb_busy_cycles got=%0d exp=%0d", bcnt, e.bsy);
          end
        end
        bcnt = 0;
      end
    end
  end

  task automatic start_op(input int nv, input bit hold);
    go = 1'b1;
    n  = 4'(nv);
    sbq.push_back(model(nv, cyc));
    if (!hold) begin
      @(negedge clk);
      go = 1'b0;
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && sbq.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    vectors++;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout pending=%0d exp=0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; go = 1'b0; n = '0; go15 = 1'b0; n15 = '0;
    #3;
    vectors++;
    if ({busy, done, error, result} !== 35'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got=%h exp=0", {busy, done, error, result});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_op(7, 0);
    repeat (4) @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_before_abort got=%0b exp=1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, error, result} !== 35'd0) begin
      miscompares++;
      $display("FAIL async_abort_outputs got=%h exp=0", {busy, done, error, result});
    end
    sbq.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_op(3, 0);
    wait_drain();
  endtask

  task automatic test_small();
    start_op(0, 0);
    wait_drain();
    start_op(1, 0);
    wait_drain();
  endtask

  task automatic test_five();
    start_op(5, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      go = ~go;
      n  = 4'd2;
    end
    go = 1'b0;
    vectors++;
    if (busy !== 1'b1 || result !== 32'd0) begin
      miscompares++;
      $display("FAIL mult_in_progress busy=%0b result=%0d exp busy=1 result=0", busy, result);
    end
    wait_drain();
  endtask

  task automatic test_twelve();
    start_op(12, 0);
    wait_drain();
    repeat (3) @(negedge clk);
    vectors++;
    if (result !== 32'd479001600 || error !== 1'b0) begin
      miscompares++;
      $display("FAIL held_result got=%0d/%0b exp=479001600/0", result, error);
    end
    start_op(13, 0);
    wait_drain();
    vectors++;
    if (error !== 1'b1 || result !== 32'd0) begin
      miscompares++;
      $display("FAIL held_range_error got=%0d/%0b exp=0/1", result, error);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int k;
    k = cyc;
    start_op(4, 1);
    e = sbq[0];
    e.cyc = k + 27;
    sbq.push_back(e);
    repeat (20) @(negedge clk);
    go = 1'b0;
    wait_drain();
  endtask

  task automatic test_max15();
    int k;
    int got;
    @(negedge clk);
    go15 = 1'b1;
    n15  = 4'd13;
    k = cyc;
    @(negedge clk);
    go15 = 1'b0;
    vectors++;
    if (busy15 !== 1'b1) begin
      miscompares++;
      $display("FAIL max15_accept busy got=%0b exp=1", busy15);
    end
    got = -1;
    for (int i = 0; i < 100 && got < 0; i++) begin
      if (done15) got = cyc;
      else @(negedge clk);
    end
    vectors++;
    if (got !== k + 49) begin
      miscompares++;
      $display("FAIL max15_done_cycle got=%0d exp=%0d", got, k + 49);
    end
`ifdef FACT_OVF_CHECK_EN
    vectors++;
    if (result15 !== 32'd0 || error15 !== 1'b1) begin
      miscompares++;
      $display("FAIL max15_overflow got=%0d/%0b exp=0/1", result15, error15);
    end
`else
    vectors++;
    if (result15 !== 32'd1932053504 || error15 !== 1'b0) begin
      miscompares++;
      $display("FAIL max15_wrap got=%0d/%0b exp=1932053504/0", result15, error15);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_small();
    test_five();
    test_twelve();
    test_back_to_back();
    test_max15();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
